// File: rtl/stop_pkg.sv
// Shared definitions for the serial comma-aligned link (receiver and transmitter).
package stop_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

endpackage

// File: rtl/stop_rx.sv
// Serial byte receiver: finds comma alignment, confirms it over SYNC_COUNT
// byte boundaries, then forwards every aligned byte, flagging non-comma data.
module stop_rx
  import stop_pkg::*;
#(
  parameter logic [7:0] COMMA      = COMMA_DEFAULT,
  parameter int         SYNC_COUNT = 4
) (
  input  logic       clk32f,
  input  logic       reset,
  input  logic       in,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       active
);

  localparam int            CW       = $clog2(SYNC_COUNT + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SYNC_COUNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(SYNC_COUNT - 1);

  state_t        state;
  state_t        next_state;
  logic [7:0]    sr;
  logic [2:0]    bit_cnt;
  logic [CW-1:0] comma_cnt;
  logic          boundary;
  logic          hit;
  logic          load_out;

  assign boundary = (bit_cnt == 3'd0);
  assign hit      = (sr == COMMA);

  always_ff @(posedge clk32f) begin
    if (reset) sr <= 8'h00;
    else       sr <= {sr[6:0], in};
  end

  // State register; active mirrors the state entering ACTIVE on the same edge.
  always_ff @(posedge clk32f) begin
    if (reset) begin
      state  <= SEARCH;
      active <= 1'b0;
    end else begin
      state  <= next_state;
      active <= (next_state == ACTIVE);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      SEARCH: if (hit) next_state = SYNC;
      SYNC: begin
        if (boundary) begin
          if (!hit)                        next_state = SEARCH;
          else if (comma_cnt == CNT_LAST)  next_state = ACTIVE;
        end
      end
      ACTIVE:  next_state = ACTIVE;
      default: next_state = SEARCH;
    endcase
  end

  // A failed boundary in SYNC drops to SEARCH with bit_cnt cleared, so that
  // same cycle is never taken as a fresh comma hit.
  always_ff @(posedge clk32f) begin
    if (reset) begin
      bit_cnt   <= 3'd0;
      comma_cnt <= '0;
    end else begin
      case (state)
        SEARCH: begin
          bit_cnt   <= hit ? 3'd1 : 3'd0;
          comma_cnt <= hit ? CNT_ONE : '0;
        end
        SYNC: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (!hit) begin
              bit_cnt   <= 3'd0;
              comma_cnt <= '0;
            end else if (comma_cnt < CNT_MAX) begin
              comma_cnt <= comma_cnt + CNT_ONE;
            end
          end
        end
        ACTIVE: bit_cnt <= bit_cnt + 3'd1;
        default: begin
          bit_cnt   <= 3'd0;
          comma_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    load_out = (state == ACTIVE) && boundary;
  end

  always_ff @(posedge clk32f) begin
    if (reset) begin
      out       <= 8'h00;
      out_valid <= 1'b0;
    end else if (load_out) begin
      out       <= sr;
      out_valid <= !hit;
    end
  end

endmodule

// File: doc/stop_rx.md
STOP_RX -- requirements
Module: stop_rx

Interface
REQ-001 Parameter COMMA, default 8'hBC, SHALL be the idle/alignment symbol (K28.5) inserted by the transmitter while valid is low.
REQ-002 Parameter SYNC_COUNT, default 4, SHALL be the number of consecutive aligned COMMA bytes required to declare link active.
REQ-003 clk32f  input  1  SHALL be the single clock: serial bit clock, one bit per rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 in  input  1  SHALL be serial data, MSB of each byte first.
REQ-006 out  output  8  SHALL be the last received aligned byte.
REQ-007 out_valid  output  1  SHALL be high when out holds a non-COMMA data byte received while ACTIVE.
REQ-008 active  output  1  SHALL be high while the FSM is in ACTIVE.

Function
REQ-009 Shift register sr[7:0] SHALL load {sr[6:0], in} on every rising edge of clk32f when reset is low.
REQ-010 The FSM SHALL have states SEARCH, SYNC and ACTIVE.
REQ-011 In SEARCH, sr SHALL be compared with COMMA every cycle, at every bit offset.
REQ-012 On sr==COMMA in SEARCH: next state SYNC, comma count set to 1, bit counter bit_cnt[2:0] set to 1.
REQ-013 In SYNC and ACTIVE, bit_cnt SHALL increment modulo 8 each cycle; a byte boundary is any cycle with bit_cnt==0, i.e. exactly 8 shifts after the previous boundary.
REQ-014 SYNC, boundary, sr==COMMA: comma count increments; when it reaches SYNC_COUNT, next state is ACTIVE.
REQ-015 SYNC, boundary, sr!=COMMA: next state is SEARCH and comma count clears; the same cycle SHALL NOT be re-evaluated as a comma hit.
REQ-016 ACTIVE, boundary: out <= sr and out_valid <= (sr != COMMA); both SHALL hold until the next boundary.
REQ-017 Latency: out/out_valid SHALL update on the edge after the cycle in which sr holds the complete byte, 9 clk32f edges after that byte's first bit is sampled.
REQ-018 ACTIVE SHALL persist until reset; mid-byte COMMA patterns SHALL be ignored once the FSM has left SEARCH.
REQ-019 active SHALL be registered and go high on the same edge as the state register enters ACTIVE.
REQ-020 The comma count SHALL saturate at SYNC_COUNT and SHALL NOT wrap.
REQ-021 out and out_valid SHALL NOT change outside ACTIVE; no bytes SHALL be forwarded during SEARCH or SYNC, including the aligning commas.

Reset
REQ-022 While reset is high, on a rising edge: sr=8'h00, bit_cnt=0, comma count=0, state=SEARCH, out=8'h00, out_valid=0, active=0.
REQ-023 Reset SHALL take priority over every other event, including a boundary or state transition in the same cycle.
REQ-024 A mid-operation reset SHALL discard any partial byte; realignment SHALL restart from SEARCH.

Structure
REQ-025 Package stop_pkg SHALL hold the FSM state encodings (SEARCH=2'd0, SYNC=2'd1, ACTIVE=2'd2) and the default COMMA constant, so the transmitter side can share them.
REQ-026 The design SHALL be one module with no sub-modules; shift register, bit counter, comma counter and FSM are inline.

Verification
REQ-027 Reset: reset high for 5 edges with in toggling -> out=00, out_valid=0, active=0, state SEARCH.
REQ-028 Offset alignment: 3 random bits, then BC x4, then AA, EE -> active rises at the 4th BC boundary; out=AA valid=1, then out=EE valid=1, each held 8 cycles.
REQ-029 Insufficient sync: BC x3 then CC -> returns to SEARCH, active stays 0, out unchanged 00; BC x4 afterwards -> ACTIVE.
REQ-030 Idle in ACTIVE: AA, BC, BB -> out_valid 1, 0, 1 with out = AA, BC, BB.
REQ-031 False comma: after ACTIVE, send 8'h5E then 8'h00 (BC spans the boundary) -> no realignment; out = 5E then 00, valid=1.
REQ-032 Reset mid-ACTIVE, asserted at bit_cnt=4 -> next edge active=0, out_valid=0; a fresh BC x4 sequence re-achieves ACTIVE.
